// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty measurement path.
package pwm_meas_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle after a single load cycle.
// Assumes the upper DEN_W numerator bits are already smaller than the denominator.
module seq_restoring_div #(
  parameter int NUM_W = 32,
  parameter int DEN_W = 24,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int IT_W = $clog2(Q_W + 1);

  logic [DEN_W-1:0] rem_r;
  logic [DEN_W-1:0] den_r;
  // Remaining dividend bits drain out of the top while quotient bits fill in at the bottom.
  logic [Q_W-1:0]   lq_r;
  logic [IT_W-1:0]  iter_r;
  logic             busy_r;

  logic [DEN_W:0]   rem_sh_s;
  logic [DEN_W:0]   diff_s;
  logic             ge_s;
  logic [DEN_W-1:0] rem_nx_s;
  logic [Q_W-1:0]   lq_nx_s;

  // One restoring step; the borrow bit of the trial subtraction decides the quotient bit.
  always_comb begin
    rem_sh_s = {rem_r, lq_r[Q_W-1]};
    diff_s   = rem_sh_s - {1'b0, den_r};
    ge_s     = ~diff_s[DEN_W];
    if (ge_s) begin
      rem_nx_s = diff_s[DEN_W-1:0];
    end else begin
      rem_nx_s = rem_sh_s[DEN_W-1:0];
    end
    lq_nx_s = {lq_r[Q_W-2:0], ge_s};
  end

  assign busy = busy_r;
  assign done = busy_r & (iter_r == IT_W'(1));
  assign quot = lq_nx_s;

  // Load on start, then iterate until the last quotient bit is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= '0;
      den_r  <= '0;
      lq_r   <= '0;
      iter_r <= '0;
      busy_r <= 1'b0;
    end else if (abort) begin
      iter_r <= '0;
      busy_r <= 1'b0;
    end else if (start && !busy_r) begin
      rem_r  <= num[Q_W +: DEN_W];
      lq_r   <= num[Q_W-1:0];
      den_r  <= den;
      iter_r <= IT_W'(Q_W);
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= rem_nx_s;
      lq_r   <= lq_nx_s;
      iter_r <= iter_r - IT_W'(1);
      if (iter_r == IT_W'(1)) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an asynchronous PWM line and derives an 8-bit duty;
// flags a line that stops toggling.
module pwm_duty_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cycles,
  output logic [CNT_W-1:0]  period_cycles,
  output logic [DUTY_W-1:0] duty,
  output logic              meas_valid,
  output logic              stuck,
  output logic              stuck_level,
  output logic              overrun
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_END  = TO_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic                   s_s, rise_s, fall_s, to_fire_s;
  logic [TO_W-1:0]        to_cnt_r;
  meas_state_e            state_r, state_nx;
  logic [CNT_W-1:0]       per_cnt_r, hi_cnt_r, per_nx, hi_nx;
  logic [CNT_W-1:0]       hi_cap_r, per_cap_r;
  logic                   capture_s, div_start_s, div_busy_s, div_done_s;
  logic [DUTY_W-1:0]      div_quot_s;

  assign s_s       = sync_r[SYNC_STAGES-1];
  assign rise_s    = s_s & ~s_d_r;
  assign fall_s    = ~s_s & s_d_r;
  // An edge arriving on the very cycle the timeout would expire keeps the line alive.
  assign to_fire_s = ~rise_s & (to_cnt_r == TO_LAST);

  // Input synchroniser and edge-detect delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      s_d_r  <= s_s;
    end
  end

  // Cycles since the last rise; parks at the limit so the timeout fires only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (rise_s) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_END) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Measurement FSM next state and counter updates.
  always_comb begin
    state_nx  = state_r;
    per_nx    = per_cnt_r;
    hi_nx     = hi_cnt_r;
    capture_s = 1'b0;
    if (to_fire_s) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_nx = HIGH;
            per_nx   = CNT_W'(1);
            hi_nx    = CNT_W'(1);
          end else begin
            state_nx = IDLE;
          end
        end
        HIGH: begin
          per_nx = sat_inc(per_cnt_r);
          if (fall_s) begin
            state_nx = LOW;
          end else begin
            hi_nx = sat_inc(hi_cnt_r);
          end
        end
        LOW: begin
          if (rise_s) begin
            capture_s = 1'b1;
            state_nx  = HIGH;
            per_nx    = CNT_W'(1);
            hi_nx     = CNT_W'(1);
          end else begin
            per_nx = sat_inc(per_cnt_r);
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // FSM state and live counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      per_cnt_r <= '0;
      hi_cnt_r  <= '0;
    end else begin
      state_r   <= state_nx;
      per_cnt_r <= per_nx;
      hi_cnt_r  <= hi_nx;
    end
  end

  assign div_start_s = capture_s & ~div_busy_s;

  // Hold the captured pair alongside its in-flight divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cap_r  <= '0;
      per_cap_r <= '0;
    end else if (div_start_s) begin
      hi_cap_r  <= hi_cnt_r;
      per_cap_r <= per_cnt_r;
    end
  end

  seq_restoring_div #(
    .NUM_W(CNT_W + DUTY_W),
    .DEN_W(CNT_W),
    .Q_W  (DUTY_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start_s),
    .abort(to_fire_s),
    .num  ({hi_cnt_r, {DUTY_W{1'b0}}}),
    .den  (per_cnt_r),
    .busy (div_busy_s),
    .done (div_done_s),
    .quot (div_quot_s)
  );

  // Result registers; a timeout overrides a divide finishing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cycles   <= '0;
      period_cycles <= '0;
      duty          <= '0;
      meas_valid    <= 1'b0;
      stuck         <= 1'b0;
      stuck_level   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= capture_s & div_busy_s;
      if (to_fire_s) begin
        stuck         <= 1'b1;
        stuck_level   <= s_s;
        duty          <= s_s ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
        high_cycles   <= '0;
        period_cycles <= '0;
        meas_valid    <= 1'b1;
      end else if (div_done_s) begin
        high_cycles   <= hi_cap_r;
        period_cycles <= per_cap_r;
        duty          <= div_quot_s;
        stuck         <= 1'b0;
        meas_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: table-driven PWM patterns, random periods against
// a period-level reference model, and hand-written timeout/reset sequences.
module tb_pwm_duty_meter;

  localparam int CNT_W = 24;
  localparam int TO    = 1000;
  localparam int SYNC  = 2;
  // Input change to visible result: SYNC edges to reach the last stage, then the
  // capture/load edge plus 8 divide iterations.
  localparam int LAT   = SYNC + 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cycles, period_cycles;
  logic [7:0]       duty;
  logic             meas_valid, stuck, stuck_level, overrun;

  pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_cycles(high_cycles), .period_cycles(period_cycles), .duty(duty),
    .meas_valid(meas_valid), .stuck(stuck), .stuck_level(stuck_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int hi; int per; int duty; int stk; int cyc;} rec_t;
  typedef struct {int h; int l; int reps; int exp_hi; int exp_per; int exp_duty; int exp_ovr;} vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  int   ovr_cnt = 0;
  int   exp_ovr = 0;
  int   have_rise, prev_rise, prev_h, acc_valid, last_acc;
  vec_t tbl[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe results and overrun pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (meas_valid) got_q.push_back('{int'(high_cycles), int'(period_cycles), int'(duty), int'(stuck), cyc});
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected to finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    ovr_cnt = 0;
    exp_ovr = 0;
    have_rise = 0;
    acc_valid = 0;
  endtask

  // Reference model: each rise completes the previous period; the divider is occupied for
  // 9 cycles after an accepted capture, and captures inside that window are dropped.
  task automatic rise_event(input int h);
    int now, per;
    now = cyc;
    if (have_rise != 0) begin
      per = now - prev_rise;
      if (acc_valid == 0 || now - last_acc >= 9) begin
        exp_q.push_back('{prev_h, per, (prev_h * 256) / per, 0, now + LAT});
        acc_valid = 1;
        last_acc = now;
      end else begin
        exp_ovr++;
      end
    end
    have_rise = 1;
    prev_rise = now;
    prev_h = h;
  endtask

  task automatic drive_period(input int h, input int l);
    rise_event(h);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic final_rise();
    rise_event(0);
    pwm_in = 1'b1;
  endtask

  task automatic compare_model(input string tag);
    int n;
    check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    check($sformatf("%s.overruns", tag), ovr_cnt, exp_ovr);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].high", tag, i), got_q[i].hi, exp_q[i].hi);
      check($sformatf("%s[%0d].period", tag, i), got_q[i].per, exp_q[i].per);
      check($sformatf("%s[%0d].duty", tag, i), got_q[i].duty, exp_q[i].duty);
      check($sformatf("%s[%0d].stuck", tag, i), got_q[i].stk, 0);
      check($sformatf("%s[%0d].cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
    end
  endtask

  initial begin
    int rel, rise_c;
    tbl[0] = '{100, 156, 3, 100, 256, 100, 0};
    tbl[1] = '{1,   254, 3, 1,   255, 1,   0};
    tbl[2] = '{254, 1,   3, 254, 255, 254, 0};
    tbl[3] = '{3,   3,   6, 3,   6,   128, 3};
    tbl[4] = '{5,   5,   4, 5,   10,  128, 0};
    tbl[5] = '{7,   1,   4, 7,   8,   224, 2};

    // Reset state
    tick(2);
    check("reset.high", int'(high_cycles), 0);
    check("reset.period", int'(period_cycles), 0);
    check("reset.duty", int'(duty), 0);
    check("reset.valid", int'(meas_valid), 0);
    check("reset.stuck", int'(stuck), 0);
    check("reset.level", int'(stuck_level), 0);
    check("reset.overrun", int'(overrun), 0);

    // Table-driven repeated patterns
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int r = 0; r < tbl[t].reps; r++) drive_period(tbl[t].h, tbl[t].l);
      final_rise();
      tick(20);
      compare_model($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d.table_overruns", t), ovr_cnt, tbl[t].exp_ovr);
      foreach (got_q[i]) begin
        check($sformatf("tbl%0d[%0d].table_high", t, i), got_q[i].hi, tbl[t].exp_hi);
        check($sformatf("tbl%0d[%0d].table_period", t, i), got_q[i].per, tbl[t].exp_per);
        check($sformatf("tbl%0d[%0d].table_duty", t, i), got_q[i].duty, tbl[t].exp_duty);
      end
    end

    // Random periods against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) drive_period(int'($urandom_range(40, 1)), int'($urandom_range(40, 1)));
    final_rise();
    tick(20);
    compare_model("rand");

    // Line held low from reset
    do_reset();
    rel = cyc;
    for (int i = 0; i < TO + 50 && stuck !== 1'b1; i++) tick(1);
    check("low.stuck", int'(stuck), 1);
    check("low.delay_in_window", int'((cyc - rel) >= TO - 2 && (cyc - rel) <= TO + 2), 1);
    tick(2);
    check("low.level", int'(stuck_level), 0);
    check("low.duty", int'(duty), 0);
    check("low.high", int'(high_cycles), 0);
    check("low.period", int'(period_cycles), 0);
    check("low.valid_pulses", got_q.size(), 1);
    if (got_q.size() > 0) check("low.valid_stuck", got_q[0].stk, 1);
    tick(TO + 100);
    check("low.no_repeat_pulse", got_q.size(), 1);
    check("low.still_stuck", int'(stuck), 1);
    got_q.delete();
    drive_period(100, 156);
    check("low.stuck_until_result", int'(stuck), 1);
    drive_period(100, 156);
    final_rise();
    tick(20);
    compare_model("restart");
    check("restart.stuck_cleared", int'(stuck), 0);

    // Line held high after one period
    do_reset();
    drive_period(50, 50);
    final_rise();
    for (int i = 0; i < TO + 50 && stuck !== 1'b1; i++) tick(1);
    tick(2);
    check("high.stuck", int'(stuck), 1);
    check("high.level", int'(stuck_level), 1);
    check("high.duty", int'(duty), 255);
    check("high.high", int'(high_cycles), 0);
    check("high.period", int'(period_cycles), 0);
    check("high.valid_pulses", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("high.first_duty", got_q[0].duty, 128);
      check("high.second_stuck", got_q[1].stk, 1);
    end

    // Reset asserted mid-HIGH, then two rises needed for a result
    do_reset();
    drive_period(30, 30);
    drive_period(30, 30);
    pwm_in = 1'b1;
    tick(10);
    #2 rst = 1'b1;
    #1;
    check("rst.high", int'(high_cycles), 0);
    check("rst.period", int'(period_cycles), 0);
    check("rst.duty", int'(duty), 0);
    check("rst.valid", int'(meas_valid), 0);
    check("rst.stuck", int'(stuck), 0);
    check("rst.overrun", int'(overrun), 0);
    tick(2);
    rst = 1'b0;
    got_q.delete();
    tick(10);
    pwm_in = 1'b0;
    tick(30);
    check("rst.no_result_first_rise", got_q.size(), 0);
    pwm_in = 1'b1;
    rise_c = cyc;
    tick(14);
    check("rst.one_result", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("rst.res_high", got_q[0].hi, 10);
      check("rst.res_period", got_q[0].per, 40);
      check("rst.res_duty", got_q[0].duty, 64);
      check("rst.res_latency", got_q[0].cyc - rise_c, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
